// File: rtl/xbar_pkg.sv
// Shared types for the crossbar master/slave protocol: command record, initiator FSM states.
// No logic; no latency; no backpressure.
// Imported by master_cmd_fifo and master_initiator.
package xbar_pkg;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xbar_cmd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } mstr_state_e;

    // Read data returned when a read is abandoned by the watchdog.
    localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/m_s_ifc.sv
// Crossbar master/slave link: the master drives req/addr/cmd/wdata, the slave answers with ack/rdata/resp.
// Wires only; no latency.
// Flow control is req/ack: the master holds req until it samples ack.
interface m_s_ifc;

    logic        req;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        resp;

    modport master_port (
        output req, addr, cmd, wdata,
        input  ack, rdata, resp
    );

    modport slave_port (
        input  req, addr, cmd, wdata,
        output ack, rdata, resp
    );

endinterface

// File: rtl/master_cmd_fifo.sv
// Registered command FIFO; head is visible combinationally on pop_dat.
// Latency: a push is visible at the head one cycle later.
// Backpressure: full while count==DEPTH; push+pop together is accepted even when full.
module master_cmd_fifo
    import xbar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  xbar_cmd_t                push_dat,
    input  logic                     pop,
    output xbar_cmd_t                pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    xbar_cmd_t       mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem_q[rptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/master_initiator.sv
// Crossbar initiator: queues host commands and runs them one at a time on m_s_ifc (MASTER_TIMEOUT_EN adds a watchdog).
// Latency: req rises one cycle after the push; read data returns one cycle after resp is sampled.
// Backpressure: cmd_ready drops while the command FIFO is full; the bus side waits on ack/resp.
module master_initiator
    import xbar_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_wr,
    input  logic [31:0]  cmd_addr,
    input  logic [31:0]  cmd_wdata,
    output logic         rsp_valid,
    output logic [31:0]  rsp_data,
    output logic         rsp_err,
    output logic         busy,
    m_s_ifc.master_port  master_ifc
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("master_initiator: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
    end

    mstr_state_e                   state_q, state_d;
    logic                          req_q, req_d;
    logic [31:0]                   addr_q, addr_d;
    logic                          cmd_q, cmd_d;
    logic [31:0]                   wdata_q, wdata_d;
    logic                          rsp_valid_q, rsp_valid_d;
    logic [31:0]                   rsp_data_q, rsp_data_d;

    xbar_cmd_t                     fifo_in, fifo_head;
    logic                          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

`ifdef MASTER_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0]                wd_q, wd_d;
    logic                          rsp_err_q, rsp_err_d;
`endif

    assign fifo_in   = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    master_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .push_dat (fifo_in),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        cmd_d       = cmd_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        fifo_pop    = 1'b0;
`ifdef MASTER_TIMEOUT_EN
        rsp_err_d   = 1'b0;
        wd_d        = '0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    addr_d   = fifo_head.addr;
                    cmd_d    = fifo_head.wr;
                    wdata_d  = fifo_head.wdata;
                    req_d    = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // req must fall on the ack edge or the slave would take the command twice.
                if (master_ifc.ack) begin
                    req_d = 1'b0;
                    if (cmd_q) begin
                        state_d = IDLE;
                    end else if (master_ifc.resp) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = master_ifc.rdata;
                        state_d     = IDLE;
                    end else begin
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (master_ifc.resp) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = master_ifc.rdata;
                    state_d     = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
`ifdef MASTER_TIMEOUT_EN
        if ((state_q == REQ || state_q == WAIT_RESP) && state_d == state_q) begin
            if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                req_d       = 1'b0;
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_data_d  = cmd_q ? 32'h0 : DEADBEEF;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= '0;
            cmd_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            cmd_q       <= cmd_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef MASTER_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
            wd_q        <= wd_d;
`endif
        end
    end

    assign master_ifc.req   = req_q;
    assign master_ifc.addr  = addr_q;
    assign master_ifc.cmd   = cmd_q;
    assign master_ifc.wdata = wdata_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_data         = rsp_data_q;
    assign busy             = (fifo_count != '0) || (state_q != IDLE);
`ifdef MASTER_TIMEOUT_EN
    assign rsp_err          = rsp_err_q;
`else
    assign rsp_err          = 1'b0;
`endif

endmodule

// File: tb/tb_master_initiator.sv
// Bench for master_initiator with a behavioural slave on m_s_ifc; timeout cases need MASTER_TIMEOUT_EN.
module tb_master_initiator;
    import xbar_pkg::*;

`ifdef MASTER_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 256;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        cmd_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_data;

    always #5 clk = ~clk;

    m_s_ifc bus ();

    master_initiator #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .master_ifc (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave: registered ack one cycle after req, read response resp_lat cycles after ack (0 = with ack).
    logic [31:0] mem [logic [31:0]];
    int          resp_lat   = 1;
    logic        ack_force0 = 1'b0;
    int          pcnt       = 0;
    logic [31:0] paddr;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a;
    endfunction

    always @(posedge clk) begin
        bus.ack  <= 1'b0;
        bus.resp <= 1'b0;
        if (pcnt != 0) begin
            pcnt <= pcnt - 1;
            if (pcnt == 1) begin
                bus.resp  <= 1'b1;
                bus.rdata <= rd(paddr);
            end
        end
        if (bus.req === 1'b1 && bus.ack !== 1'b1 && !ack_force0) begin
            bus.ack <= 1'b1;
            if (bus.cmd) begin
                mem[bus.addr] = bus.wdata;
            end else if (resp_lat == 0) begin
                bus.resp  <= 1'b1;
                bus.rdata <= rd(bus.addr);
            end else begin
                pcnt  <= resp_lat;
                paddr <= bus.addr;
            end
        end
    end

    // Response capture and req-across-ack watch, both sampled on the falling edge.
    logic [31:0] rq_dat [$];
    logic        rq_err [$];
    int          viol     = 0;
    logic        ack_seen = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rq_dat.push_back(rsp_data);
            rq_err.push_back(rsp_err);
        end
        if (ack_seen && bus.req === 1'b1) viol++;
        ack_seen = (bus.ack === 1'b1);
    end

    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d, output int stalls);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        stalls    = 0;
        while (!cmd_ready && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        check("push_ready", {31'b0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, {31'b0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic clear_q();
        rq_dat.delete();
        rq_err.delete();
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [6];

    initial begin
        int st;
        int stall_tot;
        int n;
        int hi;

        vt[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 1, 32'h0};
        vt[1] = '{1'b0, 32'h10, 32'h0,         1, 32'hA5A5_0001};
        vt[2] = '{1'b0, 32'h2A, 32'h0,         1, 32'h0000_002A};
        vt[3] = '{1'b1, 32'h20, 32'h1234_5678, 1, 32'h0};
        vt[4] = '{1'b0, 32'h20, 32'h0,         0, 32'h1234_5678};
        vt[5] = '{1'b0, 32'h33, 32'h0,         3, 32'h0000_0033};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_req",       {31'b0, bus.req},   32'd0);
        check("rst_addr",      bus.addr,           32'd0);
        check("rst_cmd",       {31'b0, bus.cmd},   32'd0);
        check("rst_wdata",     bus.wdata,          32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data",  rsp_data,           32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Table: single commands, each run to completion.
        for (int i = 0; i < 6; i++) begin
            resp_lat = vt[i].lat;
            clear_q();
            push(vt[i].wr, vt[i].addr, vt[i].wdata, st);
            drain($sformatf("vec%0d", i));
            if (vt[i].wr) begin
                check($sformatf("vec%0d_rsp_count", i), rq_dat.size(), 32'd0);
            end else begin
                check($sformatf("vec%0d_rsp_count", i), rq_dat.size(), 32'd1);
                if (rq_dat.size() >= 1) begin
                    check($sformatf("vec%0d_rsp_data", i), rq_dat[0], vt[i].exp);
                    check($sformatf("vec%0d_rsp_err", i), {31'b0, rq_err[0]}, 32'd0);
                end
            end
        end

        // Five reads pushed without a gap: FIFO fills after the fifth push, frees on the next pop.
        resp_lat  = 1;
        stall_tot = 0;
        clear_q();
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 32'h50 + 32'(i), 32'h0, st);
            stall_tot += st;
        end
        check("fill_stalls", stall_tot, 32'd0);
        check("fill_full_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("fill_ready_after_pop", {31'b0, cmd_ready}, 32'd1);
        drain("fill");
        check("fill_rsp_count", rq_dat.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rq_dat.size()) check($sformatf("fill_rsp%0d", i), rq_dat[i], 32'h50 + 32'(i));
        end

        // Back-to-back reads 1,2,3.
        clear_q();
        for (int i = 1; i <= 3; i++) push(1'b0, 32'(i), 32'h0, st);
        drain("b2b");
        check("b2b_rsp_count", rq_dat.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rq_dat.size()) check($sformatf("b2b_rsp%0d", i), rq_dat[i], 32'(i + 1));
        end

        // Reset while waiting for a slow read response; the late resp must be ignored.
        resp_lat = 5;
        clear_q();
        push(1'b0, 32'h60, 32'h0, st);
        n = 0;
        while (bus.ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_ack_seen", {31'b0, bus.ack}, 32'd1);
        @(negedge clk);
        check("rst_mid_waiting_req", {31'b0, bus.req}, 32'd0);
        check("rst_mid_waiting_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rst_mid_req",       {31'b0, bus.req},   32'd0);
        check("rst_mid_busy",      {31'b0, busy},      32'd0);
        check("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        repeat (8) @(negedge clk);
        check("rst_mid_no_rsp", rq_dat.size(), 32'd0);
        resp_lat = 1;
        push(1'b0, 32'h61, 32'h0, st);
        drain("rst_after");
        check("rst_after_rsp_count", rq_dat.size(), 32'd1);
        if (rq_dat.size() >= 1) check("rst_after_rsp_data", rq_dat[0], 32'h61);

`ifdef MASTER_TIMEOUT_EN
        // Slave never acks: watchdog drops req after TO_CYC cycles and reports an error.
        ack_force0 = 1'b1;
        clear_q();
        push(1'b0, 32'h77, 32'h0, st);
        n  = 0;
        hi = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.req === 1'b1) hi++;
        end
        check("to_rd_req_cycles", hi, 32'(TO_CYC));
        @(negedge clk);
        check("to_rd_rsp_count", rq_dat.size(), 32'd1);
        if (rq_dat.size() >= 1) begin
            check("to_rd_data", rq_dat[0], 32'hDEAD_BEEF);
            check("to_rd_err",  {31'b0, rq_err[0]}, 32'd1);
        end
        clear_q();
        push(1'b1, 32'h78, 32'h5555_AAAA, st);
        drain("to_wr");
        check("to_wr_rsp_count", rq_dat.size(), 32'd1);
        if (rq_dat.size() >= 1) begin
            check("to_wr_data", rq_dat[0], 32'h0);
            check("to_wr_err",  {31'b0, rq_err[0]}, 32'd1);
        end
        ack_force0 = 1'b0;
`endif

        check("req_across_ack", viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
